irrigation_cycle_sequencer: RTL and testbench
=============================================

// Module: irrigation_cycle_sequencer
// PURPOSE
//  Timed actuator stage downstream of the irrigation controller/selector logic.
//  Turns the level request irrigation_on plus splinker_mode_on into one bounded
//  watering cycle: timed run, then a settle (lockout) period.
//  Drives splinker_bomb / dripper_valvule and supplies two BCD countdown digits
//  to the display_driver data inputs. Forces valves off on conflicting_values.
// PARAMETERS
//  TICK_DIV          50_000_000  clock cycles per 1 s tick (>=2)
//  SPRINKLER_SECONDS 30          sprinkler run length, s (1..99)
//  DRIPPER_SECONDS   60          dripper run length, s (1..99)
//  SETTLE_SECONDS    5           post-run/abort lockout, s (1..99)
// PORTS
//  clock              in   1  system clock; all state updates on rising edge
//  reset              in   1  synchronous, active-high
//  irrigation_on      in   1  prerequisites met (level request)
//  splinker_mode_on   in   1  1 = sprinkler, 0 = dripper; sampled at cycle start
//  conflicting_values in   1  water-sensor fault
//  splinker_bomb      out  1  sprinkler pump drive
//  dripper_valvule    out  1  dripper valve drive
//  seconds_tens       out  4  BCD tens of remaining seconds
//  seconds_ones       out  4  BCD ones of remaining seconds
//  cycle_active       out  1  1 while in RUN
//  cycle_done         out  1  one-clock pulse on normal RUN completion
//  fault              out  1  1 while in FAULT
// BEHAVIOUR
//  - All outputs registered. On any edge with reset=1: state=IDLE, prescaler=0,
//    all outputs 0. This overrides everything, including mid-cycle.
//  - Tick: prescaler counts 0..TICK_DIV-1; tick=1 at TICK_DIV-1, then wraps.
//    The prescaler clears on every state entry, so the first tick comes
//    TICK_DIV clocks after entry.
//  - States: IDLE, RUN, SETTLE, FAULT. Checked in this priority order per edge:
//    1. conflicting_values=1 in any state -> FAULT. Valves 0, digits 00,
//       cycle_active 0, fault 1. This beats a simultaneous tick or completion.
//    2. IDLE & irrigation_on=1 -> RUN.
//       Latch mode; load count = SPRINKLER_SECONDS or DRIPPER_SECONDS.
//       Set the selected valve to 1 and cycle_active to 1.
//    3. RUN & irrigation_on=0 -> SETTLE (abort). Valves 0;
//       count = SETTLE_SECONDS; no cycle_done.
//    4. RUN & tick & count==01 -> SETTLE. Valves 0; count = SETTLE_SECONDS;
//       cycle_done=1 for that one clock.
//    5. RUN/SETTLE & tick & count>01 -> decrement BCD by 1
//       (ones 0 -> 9 with a tens borrow, e.g. 10 -> 09).
//    6. SETTLE & tick & count==01 -> IDLE, count 00. A still-high irrigation_on
//       starts a new RUN on the following edge.
//    7. FAULT & conflicting_values=0 -> SETTLE, count = SETTLE_SECONDS, fault 0.
//  - A splinker_mode_on change during RUN is ignored. Both valves are never 1
//    together.
//  - Run time = N*TICK_DIV clocks exactly. Digits show N at entry and 01 in
//    the last second. They never show 00 while in RUN.
//  - Display digits hold 00 in IDLE and FAULT. Illegal BCD codes never appear.
//  - An illegal state encoding recovers to IDLE with all outputs 0.
// STRUCTURE
//  - Shared package irrigation_pkg: state enum (IDLE/RUN/SETTLE/FAULT) and the
//    4-bit BCD digit type. Add the parameter-to-BCD conversion here as a
//    function (tens = N/10, ones = N%10), used at elaboration only.
//  - One sub-module, tick_generator: parameter TICK_DIV; ports clock, reset,
//    clear, tick. Reused by the display/matrix clock-reduction path.
//  - The BCD down-counter and FSM stay inline.
// TESTING  (TICK_DIV=4, SPRINKLER=3, DRIPPER=12, SETTLE=2)
//  1. reset, then irrigation_on=1, mode=1
//     -> splinker_bomb=1, digits 03->02->01 every 4 clocks.
//     Bomb drops after exactly 12 clocks, cycle_done pulses once.
//     SETTLE shows 02, 01, then IDLE 00 and a re-RUN on the next edge.
//  2. mode=0, hold on -> dripper_valvule=1, digits 12, 11, 10, 09 (borrow).
//     Toggling mode mid-RUN leaves dripper_valvule=1 and splinker_bomb=0.
//  3. drop irrigation_on 5 clocks into RUN -> valve 0 on the next edge,
//     SETTLE 02, no cycle_done.
//  4. conflicting_values=1 on the same edge as the final RUN tick
//     -> FAULT, fault=1, valves 0, digits 00, no cycle_done.
//     Clearing it -> SETTLE 02, then IDLE.
//  5. reset=1 for one clock mid-RUN at count 02
//     -> next edge: all outputs 0, IDLE; no pulse.
//  6. Random stimulus with assertions: valves never both 1; digits always BCD;
//     cycle_done only follows RUN with count 01.

Source files
------------

// File: rtl/irrigation_pkg.sv
// Shared types for the irrigation actuator path: FSM state encoding, BCD digit
// type and an elaboration-time seconds-to-BCD helper.
package irrigation_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SETTLE = 2'd2,
    FAULT  = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  // Packs {tens, ones}; only used for parameter constants (n in 0..99).
  function automatic logic [7:0] to_bcd2(input int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

endpackage

// File: rtl/irrigation_cycle_sequencer_if.sv
// Request/status bundle between the irrigation controller and the cycle
// sequencer; the sequencer sits on the slave side.
interface irrigation_cycle_sequencer_if;
  import irrigation_pkg::*;

  logic irrigation_on;
  logic splinker_mode_on;
  logic conflicting_values;
  logic splinker_bomb;
  logic dripper_valvule;
  bcd_t seconds_tens;
  bcd_t seconds_ones;
  logic cycle_active;
  logic cycle_done;
  logic fault;

  modport master (
    output irrigation_on, splinker_mode_on, conflicting_values,
    input  splinker_bomb, dripper_valvule, seconds_tens, seconds_ones,
           cycle_active, cycle_done, fault
  );

  modport slave (
    input  irrigation_on, splinker_mode_on, conflicting_values,
    output splinker_bomb, dripper_valvule, seconds_tens, seconds_ones,
           cycle_active, cycle_done, fault
  );

endinterface

// File: rtl/tick_generator.sv
// Free-running prescaler producing a one-clock tick every TICK_DIV clocks;
// clear restarts the period so the next tick lands TICK_DIV clocks later.
module tick_generator #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] prescaler_reg;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      prescaler_reg <= '0;
    end else if (prescaler_reg == LAST) begin
      prescaler_reg <= '0;
    end else begin
      prescaler_reg <= prescaler_reg + W'(1);
    end
  end

  assign tick = (prescaler_reg == LAST);

endmodule

// File: rtl/irrigation_cycle_sequencer.sv
// Runs one bounded watering cycle (timed RUN, then SETTLE lockout) per request,
// drives the selected valve and a two-digit BCD countdown for the display.
module irrigation_cycle_sequencer
  import irrigation_pkg::*;
#(
  parameter int TICK_DIV          = 50_000_000,
  parameter int SPRINKLER_SECONDS = 30,
  parameter int DRIPPER_SECONDS   = 60,
  parameter int SETTLE_SECONDS    = 5
) (
  input logic clock,
  input logic reset,
  irrigation_cycle_sequencer_if.slave bus
);

  localparam logic [7:0] SPRINKLER_BCD = to_bcd2(SPRINKLER_SECONDS);
  localparam logic [7:0] DRIPPER_BCD   = to_bcd2(DRIPPER_SECONDS);
  localparam logic [7:0] SETTLE_BCD    = to_bcd2(SETTLE_SECONDS);

  state_t state_reg;
  bcd_t   tens_reg;
  bcd_t   ones_reg;
  logic   bomb_reg;
  logic   dripper_reg;
  logic   active_reg;
  logic   done_reg;
  logic   fault_reg;

  logic tick;
  logic prescaler_clear;
  logic last_second;

  // IDLE/FAULT hold the prescaler at zero so RUN and SETTLE entries from them
  // start a full period; a completion tick wraps it naturally, only an abort
  // has to clear it explicitly.
  always_comb begin
    prescaler_clear = 1'b1;
    case (state_reg)
      RUN:     prescaler_clear = ~bus.irrigation_on;
      SETTLE:  prescaler_clear = 1'b0;
      default: prescaler_clear = 1'b1;
    endcase
  end

  tick_generator #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock(clock),
    .reset(reset),
    .clear(prescaler_clear),
    .tick (tick)
  );

  assign last_second = (tens_reg == 4'd0) && (ones_reg == 4'd1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      tens_reg    <= '0;
      ones_reg    <= '0;
      bomb_reg    <= 1'b0;
      dripper_reg <= 1'b0;
      active_reg  <= 1'b0;
      done_reg    <= 1'b0;
      fault_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (bus.conflicting_values) begin
        state_reg   <= FAULT;
        tens_reg    <= '0;
        ones_reg    <= '0;
        bomb_reg    <= 1'b0;
        dripper_reg <= 1'b0;
        active_reg  <= 1'b0;
        fault_reg   <= 1'b1;
      end else begin
        case (state_reg)
          IDLE: begin
            if (bus.irrigation_on) begin
              state_reg <= RUN;
              // The valve registers themselves hold the latched mode.
              bomb_reg    <= bus.splinker_mode_on;
              dripper_reg <= ~bus.splinker_mode_on;
              active_reg  <= 1'b1;
              {tens_reg, ones_reg} <= bus.splinker_mode_on ? SPRINKLER_BCD : DRIPPER_BCD;
            end
          end
          RUN: begin
            if (!bus.irrigation_on || (tick && last_second)) begin
              state_reg   <= SETTLE;
              bomb_reg    <= 1'b0;
              dripper_reg <= 1'b0;
              active_reg  <= 1'b0;
              done_reg    <= bus.irrigation_on;
              {tens_reg, ones_reg} <= SETTLE_BCD;
            end else if (tick) begin
              if (ones_reg == 4'd0) begin
                ones_reg <= 4'd9;
                tens_reg <= tens_reg - 4'd1;
              end else begin
                ones_reg <= ones_reg - 4'd1;
              end
            end
          end
          SETTLE: begin
            if (tick && last_second) begin
              state_reg <= IDLE;
              tens_reg  <= '0;
              ones_reg  <= '0;
            end else if (tick) begin
              if (ones_reg == 4'd0) begin
                ones_reg <= 4'd9;
                tens_reg <= tens_reg - 4'd1;
              end else begin
                ones_reg <= ones_reg - 4'd1;
              end
            end
          end
          FAULT: begin
            state_reg <= SETTLE;
            fault_reg <= 1'b0;
            {tens_reg, ones_reg} <= SETTLE_BCD;
          end
          default: begin
            state_reg   <= IDLE;
            tens_reg    <= '0;
            ones_reg    <= '0;
            bomb_reg    <= 1'b0;
            dripper_reg <= 1'b0;
            active_reg  <= 1'b0;
            fault_reg   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.splinker_bomb   = bomb_reg;
  assign bus.dripper_valvule = dripper_reg;
  assign bus.seconds_tens    = tens_reg;
  assign bus.seconds_ones    = ones_reg;
  assign bus.cycle_active    = active_reg;
  assign bus.cycle_done      = done_reg;
  assign bus.fault           = fault_reg;

endmodule

// File: tb/tb_irrigation_cycle_sequencer.sv
// Table-driven check of the irrigation cycle sequencer with a scoreboard queue,
// followed by a random phase guarded by per-cycle invariant checks.
module tb_irrigation_cycle_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  irrigation_cycle_sequencer_if bus ();

  irrigation_cycle_sequencer #(
    .TICK_DIV(4), .SPRINKLER_SECONDS(3), .DRIPPER_SECONDS(12), .SETTLE_SECONDS(2)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  typedef struct {
    string      name;
    logic       rst, on, mode, conf;
    int         cycles;
    logic       bomb, drip;
    logic [7:0] digits;
    logic       active;
    int         dones;
    logic       fault;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;

  function automatic void add(string name, logic r, logic on, logic mode, logic conf,
                              int cyc, logic bomb, logic drip, logic [7:0] digits,
                              logic active, int dones, logic fault);
    vec_t v;
    v.name = name; v.rst = r; v.on = on; v.mode = mode; v.conf = conf;
    v.cycles = cyc; v.bomb = bomb; v.drip = drip; v.digits = digits;
    v.active = active; v.dones = dones; v.fault = fault;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, string what, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s.%s: got %0h, expected %0h", name, what, act, exp);
    end
  endtask

  // Invariants that must hold on every cycle once out of the initial reset.
  logic       prev_active = 1'b0;
  logic [7:0] prev_digits = 8'h00;
  always @(negedge clk) begin
    if (mon_en) begin
      tests += 3;
      if (bus.splinker_bomb && bus.dripper_valvule) begin
        fails++;
        $display("FAIL inv_valves: both valves 1");
      end
      if (bus.seconds_tens > 4'd9 || bus.seconds_ones > 4'd9) begin
        fails++;
        $display("FAIL inv_bcd: digits %0h%0h not BCD", bus.seconds_tens, bus.seconds_ones);
      end
      if (bus.cycle_done && !(prev_active && prev_digits == 8'h01)) begin
        fails++;
        $display("FAIL inv_done: cycle_done after active=%0b digits=%0h, expected RUN at 01",
                 prev_active, prev_digits);
      end
    end
    prev_active = bus.cycle_active;
    prev_digits = {bus.seconds_tens, bus.seconds_ones};
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t e;
    int   done_seen;

    bus.irrigation_on = 1'b0;
    bus.splinker_mode_on = 1'b0;
    bus.conflicting_values = 1'b0;

    // name, rst,on,mode,conf, cycles, bomb,drip, digits, active, dones, fault
    add("reset",         1,0,0,0, 2, 0,0,8'h00,0,0,0);
    add("s1_enter",      0,1,1,0, 1, 1,0,8'h03,1,0,0);
    add("s1_hold03",     0,1,1,0, 3, 1,0,8'h03,1,0,0);
    add("s1_02",         0,1,1,0, 1, 1,0,8'h02,1,0,0);
    add("s1_01",         0,1,1,0, 4, 1,0,8'h01,1,0,0);
    add("s1_last",       0,1,1,0, 3, 1,0,8'h01,1,0,0);
    add("s1_done",       0,1,1,0, 1, 0,0,8'h02,0,1,0);
    add("s1_set01",      0,1,1,0, 4, 0,0,8'h01,0,0,0);
    add("s1_idle",       0,1,1,0, 4, 0,0,8'h00,0,0,0);
    add("s1_rerun",      0,1,1,0, 1, 1,0,8'h03,1,0,0);
    add("s1_drop",       0,0,1,0, 1, 0,0,8'h02,0,0,0);
    add("s1_drop01",     0,0,1,0, 4, 0,0,8'h01,0,0,0);
    add("s1_drop_idle",  0,0,1,0, 4, 0,0,8'h00,0,0,0);
    add("s2_enter",      0,1,0,0, 1, 0,1,8'h12,1,0,0);
    add("s2_11",         0,1,0,0, 4, 0,1,8'h11,1,0,0);
    add("s2_10",         0,1,0,0, 4, 0,1,8'h10,1,0,0);
    add("s2_09_modeflip",0,1,1,0, 4, 0,1,8'h09,1,0,0);
    add("s2_08",         0,1,1,0, 4, 0,1,8'h08,1,0,0);
    add("s2_abort",      0,0,1,0, 1, 0,0,8'h02,0,0,0);
    add("s2_idle",       0,0,1,0, 8, 0,0,8'h00,0,0,0);
    add("s3_enter",      0,1,1,0, 1, 1,0,8'h03,1,0,0);
    add("s3_02",         0,1,1,0, 4, 1,0,8'h02,1,0,0);
    add("s3_abort",      0,0,1,0, 1, 0,0,8'h02,0,0,0);
    add("s3_settle_hold",0,0,1,0, 3, 0,0,8'h02,0,0,0);
    add("s3_settle01",   0,0,1,0, 1, 0,0,8'h01,0,0,0);
    add("s3_idle",       0,0,1,0, 4, 0,0,8'h00,0,0,0);
    add("s4_enter",      0,1,1,0, 1, 1,0,8'h03,1,0,0);
    add("s4_last",       0,1,1,0,11, 1,0,8'h01,1,0,0);
    add("s4_fault",      0,1,1,1, 1, 0,0,8'h00,0,0,1);
    add("s4_fault_hold", 0,1,1,1, 3, 0,0,8'h00,0,0,1);
    add("s4_clear",      0,0,1,0, 1, 0,0,8'h02,0,0,0);
    add("s4_set01",      0,0,1,0, 4, 0,0,8'h01,0,0,0);
    add("s4_idle",       0,0,1,0, 4, 0,0,8'h00,0,0,0);
    add("s5_enter",      0,1,1,0, 1, 1,0,8'h03,1,0,0);
    add("s5_02",         0,1,1,0, 4, 1,0,8'h02,1,0,0);
    add("s5_reset",      1,1,1,0, 1, 0,0,8'h00,0,0,0);
    add("s5_rerun",      0,1,0,0, 1, 0,1,8'h12,1,0,0);
    add("s5_11",         0,1,0,0, 4, 0,1,8'h11,1,0,0);
    add("s5_drop",       0,0,0,0, 1, 0,0,8'h02,0,0,0);
    add("s5_fault",      0,0,0,1, 1, 0,0,8'h00,0,0,1);
    add("s5_fault_idle", 0,0,0,0, 9, 0,0,8'h00,0,0,0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      bus.irrigation_on = vecs[i].on;
      bus.splinker_mode_on = vecs[i].mode;
      bus.conflicting_values = vecs[i].conf;
      exp_q.push_back(vecs[i]);
      done_seen = 0;
      for (int c = 0; c < vecs[i].cycles; c++) begin
        @(posedge clk);
        #1;
        if (bus.cycle_done === 1'b1) done_seen++;
      end
      mon_en = 1'b1;
      e = exp_q.pop_front();
      chk(e.name, "splinker_bomb", int'(bus.splinker_bomb), int'(e.bomb));
      chk(e.name, "dripper_valvule", int'(bus.dripper_valvule), int'(e.drip));
      chk(e.name, "digits", int'({bus.seconds_tens, bus.seconds_ones}), int'(e.digits));
      chk(e.name, "cycle_active", int'(bus.cycle_active), int'(e.active));
      chk(e.name, "cycle_done_pulses", done_seen, e.dones);
      chk(e.name, "fault", int'(bus.fault), int'(e.fault));
      $display("[TB] step %-15s digits=%0h%0h bomb=%0b drip=%0b active=%0b done_pulses=%0d fault=%0b",
               e.name, bus.seconds_tens, bus.seconds_ones, bus.splinker_bomb,
               bus.dripper_valvule, bus.cycle_active, done_seen, bus.fault);
    end

    // Random phase: invariants are checked by the negedge monitor.
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      bus.irrigation_on = ($urandom_range(0, 9) < 7);
      bus.splinker_mode_on = $urandom_range(0, 1) == 1;
      bus.conflicting_values = ($urandom_range(0, 59) == 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
